// File: rtl/muldiv32_if.sv
// Operand/result bundle between the EX-stage issue logic and the mul/div unit.
// The master drives operands, start and the MTHI/MTLO writes; the slave returns status and HI/LO.
interface muldiv32_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv32.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding HI/LO: one magnitude iteration per clock,
// followed by a single sign-fixup cycle that writes HI/LO and pulses done.
module muldiv32 #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      reset,
    muldiv32_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state_reg;
    logic               is_div_reg;
    logic [CW-1:0]      cnt_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0]   opnd_reg;
    logic [WIDTH-1:0]   a_orig_reg;
    logic               b_zero_reg;
    logic               neg_q_reg;
    logic               neg_r_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;

    logic               is_signed;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quot_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    always_comb begin
        is_signed = ~bus.op[0];
        mag_a     = (is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        mag_b     = (is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

        // Multiply: multiplier sits in the low half and is consumed LSB first.
        mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, (acc_reg[0] ? opnd_reg : {WIDTH{1'b0}})};
        mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

        // Divide: partial remainder in the high half, dividend/quotient shifting through the low half.
        div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_reg};
        div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0],  acc_reg[WIDTH-2:0], 1'b1};

        prod_fixed = neg_q_reg ? -acc_reg : acc_reg;
        quot_fixed = neg_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
        rem_fixed  = neg_r_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            is_div_reg <= 1'b0;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            opnd_reg   <= '0;
            a_orig_reg <= '0;
            b_zero_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.hi_we) hi_reg <= bus.wdata;
                    if (bus.lo_we) lo_reg <= bus.wdata;
                    if (bus.start) begin
                        state_reg  <= CALC;
                        busy_reg   <= 1'b1;
                        cnt_reg    <= '0;
                        is_div_reg <= bus.op[1];
                        opnd_reg   <= bus.op[1] ? mag_b : mag_a;
                        acc_reg    <= {{WIDTH{1'b0}}, (bus.op[1] ? mag_a : mag_b)};
                        a_orig_reg <= bus.a;
                        b_zero_reg <= (bus.b == '0);
                        neg_q_reg  <= is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        neg_r_reg  <= is_signed & bus.a[WIDTH-1];
                    end
                end
                CALC: begin
                    acc_reg <= is_div_reg ? div_next : mul_next;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CW'(WIDTH - 1)) state_reg <= FIX;
                end
                FIX: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    if (!is_div_reg) begin
                        {hi_reg, lo_reg} <= prod_fixed;
                    end else if (b_zero_reg) begin
                        hi_reg <= a_orig_reg;
                        lo_reg <= '1;
                    end else begin
                        hi_reg <= rem_fixed;
                        lo_reg <= quot_fixed;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;
endmodule

// File: tb/tb_muldiv32.sv
// Directed bench for muldiv32: each task drives one scenario and checks HI/LO, busy, done and latency.
module tb_muldiv32;
    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

    logic clk = 1'b0;
    logic reset;
    int   passed = 0;
    int   total  = 0;

    muldiv32_if #(.WIDTH(32)) bus ();
    muldiv32 #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Presents a start for exactly one rising edge; returns at the falling edge after it.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Counts cycles after the start edge until done, noting whether busy ever dropped early.
    task automatic wait_done(output int cycles, output bit busy_ok);
        cycles = 0;
        busy_ok = 1'b1;
        while (bus.done !== 1'b1 && cycles < 100) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cycles, output bit busy_ok);
        issue(op, a, b);
        wait_done(cycles, busy_ok);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
        repeat (3) @(negedge clk);
        total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b, want 0", bus.busy); else passed++;
        total++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b, want 0", bus.done); else passed++;
        total++; if (bus.hi !== 32'h0) $display("FAIL reset_hi: got %h, want 0", bus.hi); else passed++;
        total++; if (bus.lo !== 32'h0) $display("FAIL reset_lo: got %h, want 0", bus.lo); else passed++;
        reset = 1'b0;
        @(negedge clk);
        $display("reset: busy=%b done=%b hi=%h lo=%h", bus.busy, bus.done, bus.hi, bus.lo);
    endtask

    task automatic test_mult_signed;
        int cycles; bit busy_ok;
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        total++; if (bus.busy !== 1'b1) $display("FAIL mult_busy_after_start: got %b, want 1", bus.busy); else passed++;
        wait_done(cycles, busy_ok);
        total++; if (cycles != 33) $display("FAIL mult_latency: got %0d, want 33", cycles); else passed++;
        total++; if (!busy_ok) $display("FAIL mult_busy_hold: got busy low before done, want busy high"); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL mult_busy_at_done: got %b, want 0", bus.busy); else passed++;
        total++; if (bus.hi !== 32'hFFFF_FFFF) $display("FAIL mult_hi: got %h, want ffffffff", bus.hi); else passed++;
        total++; if (bus.lo !== 32'hFFFF_FFEB) $display("FAIL mult_lo: got %h, want ffffffeb", bus.lo); else passed++;
        $display("MULT -3*7: cycles=%0d hi=%h lo=%h", cycles, bus.hi, bus.lo);
        @(negedge clk);
        total++; if (bus.done !== 1'b0) $display("FAIL mult_done_pulse: got %b, want 0", bus.done); else passed++;
    endtask

    task automatic test_mult_unsigned;
        int cycles; bit busy_ok;
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cycles, busy_ok);
        total++; if (bus.hi !== 32'hFFFF_FFFE) $display("FAIL multu_hi: got %h, want fffffffe", bus.hi); else passed++;
        total++; if (bus.lo !== 32'h0000_0001) $display("FAIL multu_lo: got %h, want 00000001", bus.lo); else passed++;
        $display("MULTU ffffffff*ffffffff: cycles=%0d hi=%h lo=%h", cycles, bus.hi, bus.lo);
        run_op(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cycles, busy_ok);
        total++; if (bus.hi !== 32'h0) $display("FAIL mult_m1_hi: got %h, want 00000000", bus.hi); else passed++;
        total++; if (bus.lo !== 32'h1) $display("FAIL mult_m1_lo: got %h, want 00000001", bus.lo); else passed++;
        $display("MULT -1*-1: cycles=%0d hi=%h lo=%h", cycles, bus.hi, bus.lo);
    endtask

    task automatic test_div;
        int cycles; bit busy_ok;
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, cycles, busy_ok);
        total++; if (bus.lo !== 32'hFFFF_FFFD) $display("FAIL div_neg_lo: got %h, want fffffffd", bus.lo); else passed++;
        total++; if (bus.hi !== 32'hFFFF_FFFF) $display("FAIL div_neg_hi: got %h, want ffffffff", bus.hi); else passed++;
        total++; if (cycles != 33) $display("FAIL div_latency: got %0d, want 33", cycles); else passed++;
        $display("DIV -7/2: cycles=%0d hi=%h lo=%h", cycles, bus.hi, bus.lo);
        run_op(OP_DIVU, 32'd7, 32'd2, cycles, busy_ok);
        total++; if (bus.lo !== 32'd3) $display("FAIL divu_lo: got %h, want 00000003", bus.lo); else passed++;
        total++; if (bus.hi !== 32'd1) $display("FAIL divu_hi: got %h, want 00000001", bus.hi); else passed++;
        $display("DIVU 7/2: cycles=%0d hi=%h lo=%h", cycles, bus.hi, bus.lo);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cycles, busy_ok);
        total++; if (bus.lo !== 32'h8000_0000) $display("FAIL div_ovf_lo: got %h, want 80000000", bus.lo); else passed++;
        total++; if (bus.hi !== 32'h0) $display("FAIL div_ovf_hi: got %h, want 00000000", bus.hi); else passed++;
        $display("DIV 80000000/-1: cycles=%0d hi=%h lo=%h", cycles, bus.hi, bus.lo);
    endtask

    task automatic test_div_zero;
        int cycles; bit busy_ok;
        run_op(OP_DIVU, 32'd100, 32'd0, cycles, busy_ok);
        total++; if (bus.lo !== 32'hFFFF_FFFF) $display("FAIL divu_zero_lo: got %h, want ffffffff", bus.lo); else passed++;
        total++; if (bus.hi !== 32'h0000_0064) $display("FAIL divu_zero_hi: got %h, want 00000064", bus.hi); else passed++;
        $display("DIVU 100/0: cycles=%0d hi=%h lo=%h", cycles, bus.hi, bus.lo);
        run_op(OP_DIV, 32'hFFFF_FFFB, 32'd0, cycles, busy_ok);
        total++; if (bus.lo !== 32'hFFFF_FFFF) $display("FAIL div_zero_lo: got %h, want ffffffff", bus.lo); else passed++;
        total++; if (bus.hi !== 32'hFFFF_FFFB) $display("FAIL div_zero_hi: got %h, want fffffffb", bus.hi); else passed++;
        $display("DIV -5/0: cycles=%0d hi=%h lo=%h", cycles, bus.hi, bus.lo);
    endtask

    task automatic test_busy_ignore;
        int cycles; bit busy_ok;
        issue(OP_MULTU, 32'd3, 32'd4);
        repeat (9) begin
            @(posedge clk);
            @(negedge clk);
        end
        bus.op = OP_DIV; bus.a = 32'd9; bus.b = 32'd3; bus.start = 1'b1;
        bus.hi_we = 1'b1; bus.wdata = 32'h55;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0; bus.hi_we = 1'b0;
        total++; if (bus.hi === 32'h55) $display("FAIL busy_mthi_ignored: got %h, want not 00000055", bus.hi); else passed++;
        wait_done(cycles, busy_ok);
        cycles += 10;
        total++; if (cycles != 33) $display("FAIL busy_latency: got %0d, want 33", cycles); else passed++;
        total++; if (bus.hi !== 32'h0) $display("FAIL busy_hi: got %h, want 00000000", bus.hi); else passed++;
        total++; if (bus.lo !== 32'd12) $display("FAIL busy_lo: got %h, want 0000000c", bus.lo); else passed++;
        $display("MULTU 3*4 with ignored start/MTHI: cycles=%0d hi=%h lo=%h", cycles, bus.hi, bus.lo);
        @(negedge clk);
        bus.lo_we = 1'b1; bus.wdata = 32'hAA;
        @(posedge clk);
        @(negedge clk);
        bus.lo_we = 1'b0;
        total++; if (bus.lo !== 32'hAA) $display("FAIL mtlo_lo: got %h, want 000000aa", bus.lo); else passed++;
        total++; if (bus.done !== 1'b0) $display("FAIL mtlo_no_done: got %b, want 0", bus.done); else passed++;
        total++; if (bus.hi !== 32'h0) $display("FAIL mtlo_hi_kept: got %h, want 00000000", bus.hi); else passed++;
        $display("MTLO aa: hi=%h lo=%h done=%b", bus.hi, bus.lo, bus.done);
    endtask

    task automatic test_write_with_start;
        int cycles; bit busy_ok;
        @(negedge clk);
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h1234;
        bus.op = OP_MULTU; bus.a = 32'd5; bus.b = 32'd5; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.start = 1'b0;
        total++; if (bus.hi !== 32'h1234) $display("FAIL same_cycle_hi: got %h, want 00001234", bus.hi); else passed++;
        total++; if (bus.busy !== 1'b1) $display("FAIL same_cycle_busy: got %b, want 1", bus.busy); else passed++;
        wait_done(cycles, busy_ok);
        total++; if (bus.lo !== 32'd25) $display("FAIL same_cycle_lo: got %h, want 00000019", bus.lo); else passed++;
        total++; if (bus.hi !== 32'h0) $display("FAIL same_cycle_hi_final: got %h, want 00000000", bus.hi); else passed++;
        $display("MTHI/MTLO+MULTU 5*5: cycles=%0d hi=%h lo=%h", cycles, bus.hi, bus.lo);
    endtask

    task automatic test_reset_abort;
        int cycles; bit busy_ok; int done_seen;
        issue(OP_DIVU, 32'd50, 32'd7);
        repeat (14) begin
            @(posedge clk);
            @(negedge clk);
        end
        #2 reset = 1'b1;
        #1;
        total++; if (bus.busy !== 1'b0) $display("FAIL abort_busy: got %b, want 0", bus.busy); else passed++;
        total++; if (bus.hi !== 32'h0) $display("FAIL abort_hi: got %h, want 00000000", bus.hi); else passed++;
        total++; if (bus.lo !== 32'h0) $display("FAIL abort_lo: got %h, want 00000000", bus.lo); else passed++;
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_seen++;
        end
        total++; if (done_seen != 0) $display("FAIL abort_no_done: got %0d pulses, want 0", done_seen); else passed++;
        $display("DIVU 50/7 aborted by reset: hi=%h lo=%h done_pulses=%0d", bus.hi, bus.lo, done_seen);
        run_op(OP_MULTU, 32'd2, 32'd3, cycles, busy_ok);
        total++; if (bus.lo !== 32'd6) $display("FAIL post_reset_lo: got %h, want 00000006", bus.lo); else passed++;
        total++; if (cycles != 33) $display("FAIL post_reset_latency: got %0d, want 33", cycles); else passed++;
        $display("MULTU 2*3 after reset: cycles=%0d hi=%h lo=%h", cycles, bus.hi, bus.lo);
    endtask

    initial begin
        test_reset();
        test_mult_signed();
        test_mult_unsigned();
        test_div();
        test_div_zero();
        test_busy_ignore();
        test_write_with_start();
        test_reset_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
